// File: rtl/eth_rx_deframer.sv
// GMII RX deframer: strips preamble/SFD and FCS, captures the MAC header, checks CRC-32/size/rx_er/address filter.
// Payload byte appears on m_data 5 cycles after it is sampled; no backpressure, the sink must accept every m_valid byte.
module eth_rx_deframer #(
    parameter logic [47:0] LOCAL_MAC = 48'h023528fbdd66,
    parameter logic        PROMISC   = 1'b0,
    parameter int          MIN_FRAME = 64,
    parameter int          MAX_FRAME = 1518
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    output logic        hdr_valid,
    output logic [47:0] dst_mac,
    output logic [47:0] src_mac,
    output logic [15:0] len_type,
    output logic        frame_good,
    output logic        frame_bad
);

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_DST, S_SRC, S_LEN, S_PAYLOAD, S_DROP
    } state_t;

    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [10:0] MIN_CNT     = 11'(MIN_FRAME);
    localparam logic [10:0] MAX_CNT     = 11'(MAX_FRAME);

    state_t           state_q, state_d;
    logic [2:0]       pre_cnt_q, pre_cnt_d;
    logic [2:0]       fld_cnt_q, fld_cnt_d;
    logic [47:0]      dst_sh_q, dst_sh_d;
    logic [47:0]      src_sh_q, src_sh_d;
    logic [7:0]       len_hi_q, len_hi_d;
    logic [31:0]      crc_q, crc_d;
    logic [10:0]      cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [3:0][7:0]  dly_q, dly_d;
    logic [2:0]       dly_cnt_q, dly_cnt_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_vld_q, hold_vld_d;

    logic [7:0]       m_data_q, m_data_d;
    logic             m_valid_q, m_valid_d;
    logic             m_last_q, m_last_d;
    logic             hdr_valid_q, hdr_valid_d;
    logic [47:0]      dst_mac_q, dst_mac_d;
    logic [47:0]      src_mac_q, src_mac_d;
    logic [15:0]      len_type_q, len_type_d;
    logic             good_q, good_d;
    logic             bad_q, bad_d;

    logic [47:0]      dst_next;
    logic             addr_ok;
    logic [31:0]      crc_next;
    logic [10:0]      cnt_inc;
    logic             frame_ok;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    assign dst_next = {dst_sh_q[39:0], gmii_rxd};
    assign addr_ok  = PROMISC || (dst_next == LOCAL_MAC) || (dst_next == 48'hFFFF_FFFF_FFFF);
    assign crc_next = crc32_byte(crc_q, gmii_rxd);
    assign cnt_inc  = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
    assign frame_ok = (crc_q == CRC_RESIDUE) && !err_q && (cnt_q >= MIN_CNT) && (cnt_q <= MAX_CNT);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (gmii_rx_dv) state_d = (gmii_rxd == 8'h55) ? S_PREAMBLE : S_DROP;
            S_PREAMBLE: begin
                if (!gmii_rx_dv)                                  state_d = S_IDLE;
                else if (gmii_rxd == 8'hD5)                       state_d = S_DST;
                else if (gmii_rxd == 8'h55 && pre_cnt_q != 3'd7)  state_d = S_PREAMBLE;
                else                                              state_d = S_DROP;
            end
            S_DST: begin
                if (!gmii_rx_dv)             state_d = S_IDLE;
                else if (fld_cnt_q == 3'd5)  state_d = addr_ok ? S_SRC : S_DROP;
            end
            S_SRC: begin
                if (!gmii_rx_dv)             state_d = S_IDLE;
                else if (fld_cnt_q == 3'd5)  state_d = S_LEN;
            end
            S_LEN: begin
                if (!gmii_rx_dv)             state_d = S_IDLE;
                else if (fld_cnt_q == 3'd1)  state_d = S_PAYLOAD;
            end
            S_PAYLOAD:  if (!gmii_rx_dv) state_d = S_IDLE;
            S_DROP:     if (!gmii_rx_dv) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pre_cnt_d   = pre_cnt_q;
        fld_cnt_d   = fld_cnt_q;
        dst_sh_d    = dst_sh_q;
        src_sh_d    = src_sh_q;
        len_hi_d    = len_hi_q;
        crc_d       = crc_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        dly_d       = dly_q;
        dly_cnt_d   = dly_cnt_q;
        hold_d      = hold_q;
        hold_vld_d  = hold_vld_q;
        m_data_d    = m_data_q;
        m_valid_d   = 1'b0;
        m_last_d    = 1'b0;
        hdr_valid_d = 1'b0;
        dst_mac_d   = dst_mac_q;
        src_mac_d   = src_mac_q;
        len_type_d  = len_type_q;
        good_d      = 1'b0;
        bad_d       = 1'b0;
        case (state_q)
            S_IDLE: pre_cnt_d = 3'd1;
            S_PREAMBLE: if (gmii_rx_dv) begin
                if (gmii_rxd == 8'h55 && pre_cnt_q != 3'd7) pre_cnt_d = pre_cnt_q + 3'd1;
                if (gmii_rxd == 8'hD5) begin
                    crc_d     = 32'hFFFF_FFFF;
                    cnt_d     = 11'd0;
                    err_d     = 1'b0;
                    fld_cnt_d = 3'd0;
                end
            end
            S_DST, S_SRC, S_LEN: begin
                if (gmii_rx_dv) begin
                    crc_d = crc_next;
                    cnt_d = cnt_inc;
                    if (gmii_rx_er) err_d = 1'b1;
                    fld_cnt_d = fld_cnt_q + 3'd1;
                    if (state_q == S_DST) begin
                        dst_sh_d = dst_next;
                        if (fld_cnt_q == 3'd5) fld_cnt_d = 3'd0;
                    end else if (state_q == S_SRC) begin
                        src_sh_d = {src_sh_q[39:0], gmii_rxd};
                        if (fld_cnt_q == 3'd5) fld_cnt_d = 3'd0;
                    end else if (fld_cnt_q == 3'd0) begin
                        len_hi_d = gmii_rxd;
                    end else begin
                        // Second length byte: publish the whole header at once.
                        fld_cnt_d   = 3'd0;
                        hdr_valid_d = 1'b1;
                        dst_mac_d   = dst_sh_q;
                        src_mac_d   = src_sh_q;
                        len_type_d  = {len_hi_q, gmii_rxd};
                    end
                end else begin
                    bad_d = 1'b1;
                end
            end
            S_PAYLOAD: begin
                if (gmii_rx_dv) begin
                    crc_d = crc_next;
                    cnt_d = cnt_inc;
                    if (gmii_rx_er) err_d = 1'b1;
                    // The newest four bytes may be FCS, so a byte only leaves the delay line once displaced.
                    dly_d = {dly_q[2:0], gmii_rxd};
                    if (dly_cnt_q == 3'd4) begin
                        hold_d     = dly_q[3];
                        hold_vld_d = 1'b1;
                        if (hold_vld_q) begin
                            m_data_d  = hold_q;
                            m_valid_d = 1'b1;
                        end
                    end else begin
                        dly_cnt_d = dly_cnt_q + 3'd1;
                    end
                end else begin
                    if (hold_vld_q) begin
                        m_data_d  = hold_q;
                        m_valid_d = 1'b1;
                        m_last_d  = 1'b1;
                    end
                    good_d     = frame_ok;
                    bad_d      = !frame_ok;
                    dly_cnt_d  = 3'd0;
                    hold_vld_d = 1'b0;
                    cnt_d      = 11'd0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_q   <= 3'd0;
            fld_cnt_q   <= 3'd0;
            dst_sh_q    <= 48'd0;
            src_sh_q    <= 48'd0;
            len_hi_q    <= 8'd0;
            crc_q       <= 32'hFFFF_FFFF;
            cnt_q       <= 11'd0;
            err_q       <= 1'b0;
            dly_q       <= '0;
            dly_cnt_q   <= 3'd0;
            hold_q      <= 8'd0;
            hold_vld_q  <= 1'b0;
            m_data_q    <= 8'd0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            hdr_valid_q <= 1'b0;
            dst_mac_q   <= 48'd0;
            src_mac_q   <= 48'd0;
            len_type_q  <= 16'd0;
            good_q      <= 1'b0;
            bad_q       <= 1'b0;
        end else begin
            pre_cnt_q   <= pre_cnt_d;
            fld_cnt_q   <= fld_cnt_d;
            dst_sh_q    <= dst_sh_d;
            src_sh_q    <= src_sh_d;
            len_hi_q    <= len_hi_d;
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            dly_q       <= dly_d;
            dly_cnt_q   <= dly_cnt_d;
            hold_q      <= hold_d;
            hold_vld_q  <= hold_vld_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            hdr_valid_q <= hdr_valid_d;
            dst_mac_q   <= dst_mac_d;
            src_mac_q   <= src_mac_d;
            len_type_q  <= len_type_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
        end
    end

    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign m_last     = m_last_q;
    assign hdr_valid  = hdr_valid_q;
    assign dst_mac    = dst_mac_q;
    assign src_mac    = src_mac_q;
    assign len_type   = len_type_q;
    assign frame_good = good_q;
    assign frame_bad  = bad_q;

endmodule

// File: doc/eth_rx_deframer.md
Name: eth_rx_deframer

Overview:
Receive-side counterpart to the frame encapsulator. Consumes GMII receive bytes, strips the preamble and SFD, and captures the destination MAC, source MAC and length/type fields. Streams the payload out byte-wide with the FCS removed, then reports frame status after checking CRC-32, size, receive errors and the address filter. Sits between the GMII RX pins and the RX payload buffer.

Parameters:
LOCAL_MAC, 48'h023528fbdd66, station address accepted by the address filter.
PROMISC, 1'b0, 1 = accept any destination address.
MIN_FRAME, 64, minimum byte count from destination MAC through FCS inclusive.
MAX_FRAME, 1518, maximum byte count from destination MAC through FCS inclusive.

Ports:
clk  in  1  receive clock; one GMII byte per cycle.
rst  in  1  synchronous, active-high reset.
gmii_rxd  in  8  receive data byte.
gmii_rx_dv  in  1  receive data valid.
gmii_rx_er  in  1  receive error.
m_data  out  8  payload byte.
m_valid  out  1  m_data valid; no backpressure, so the sink must accept every valid byte.
m_last  out  1  marks the final payload byte.
hdr_valid  out  1  one-cycle pulse when the header fields below are updated.
dst_mac  out  48  received destination MAC, first byte on the wire in bits [47:40].
src_mac  out  48  received source MAC, same byte order.
len_type  out  16  length/type field, first byte in bits [15:8].
frame_good  out  1  one-cycle pulse: frame accepted.
frame_bad  out  1  one-cycle pulse: frame rejected after its header was accepted.

Behaviour:
- Reset: state IDLE, all outputs 0, delay line and holding register empty, byte counter 0, error flag 0.
- All inputs are sampled on posedge clk and all outputs are registered.
- States: IDLE, PREAMBLE, DST, SRC, LEN, PAYLOAD, DROP.
- IDLE:
  - dv=1 and rxd=0x55 -> PREAMBLE.
  - dv=1 with any other byte -> DROP.
- PREAMBLE:
  - 0x55 -> stay, up to 7 consecutive 0x55 bytes in total.
  - 0xD5 -> DST; CRC register set to 0xFFFFFFFF and byte counter cleared.
  - Any other byte, or an 8th 0x55 -> DROP.
  - dv=0 -> IDLE, with no output.
- DST, then SRC, then LEN: 6, 6 and 2 bytes, each shifted into its field register.
- Address filter, evaluated when the 6th DST byte is sampled:
  - Accept if dst equals LOCAL_MAC, or dst is 48'hFFFFFFFFFFFF, or PROMISC=1.
  - Otherwise go to DROP; no pulses and no header update.
- hdr_valid pulses in the cycle after the 2nd LEN byte is sampled; state -> PAYLOAD. The field registers then hold until the next hdr_valid.
- Header truncation: dv=0 in DST, SRC or LEN -> frame_bad pulse and IDLE.
  - Exception: no pulse if the address filter has already rejected the frame, because the block is then in DROP.
- DROP: ignore all input until dv=0 is sampled, then go to IDLE. No outputs are produced.
- CRC-32 (reflected, polynomial 0xEDB88320, LSB-first per byte):
  - Updated on every byte from the first DST byte through the last FCS byte.
  - The check passes if the register equals residue 0xDEBB20E3 at end of frame.
- Byte counter: 11 bits, counts from DST through FCS, saturates at 2047.
- Error flag: set by gmii_rx_er=1 on any dv=1 cycle from DST onward; cleared at the SFD.
- FCS stripping in PAYLOAD:
  - Each byte enters a 4-byte delay line.
  - When the delay line is full, the byte it displaces moves into a holding register.
  - If the holding register was already occupied, its previous content is emitted on the next cycle with m_valid=1 and m_last=0.
  - Resulting latency: 5 cycles from a payload byte being sampled to it appearing on m_data.
- End of frame, on the first posedge sampling dv=0 in PAYLOAD:
  - If the holding register is occupied, emit it with m_valid=1 and m_last=1 in the next cycle.
  - In that same cycle pulse exactly one of frame_good or frame_bad.
  - frame_good requires: CRC passes, error flag clear, and MIN_FRAME <= count <= MAX_FRAME.
  - Otherwise frame_bad. Oversize frames are still received to the end, not cut off.
  - If the holding register is empty, the status pulses alone, with no m_valid.
  - Then go to IDLE; the delay line, holding register and count are cleared.
- Back-to-back frames: a new 0x55 with dv=1 in the cycle immediately after dv falls is accepted normally.
- Reset mid-frame:
  - Everything returns to IDLE immediately; no m_last or status pulse is generated for the aborted frame.
  - If dv is still high on a non-preamble byte after reset, the rest of that frame is dropped via DROP.
- Payload bytes already emitted before a frame turns out bad are not retracted. The sink discards them on frame_bad.

Test Plan:
- 7x0x55, 0xD5, dst=LOCAL_MAC, src=0x072227ACDB65, len=0x002E, payload 0x00..0x2D, correct FCS (64 bytes):
  - One hdr_valid with dst_mac, src_mac and len_type matching.
  - 46 m_valid bytes 0x00..0x2D; m_last only on 0x2D.
  - frame_good=1 coincident with m_last; frame_bad never pulses.
- Same frame with one FCS bit flipped -> identical payload stream, then frame_bad pulse and no frame_good.
- dst=0x112233445566 with PROMISC=0 -> no hdr_valid, m_valid, frame_good or frame_bad. Repeat with dst=FF:FF:FF:FF:FF:FF -> accepted, frame_good.
- gmii_rx_er=1 for one cycle mid-payload of an otherwise valid frame -> frame_bad. A following valid frame sent back-to-back -> frame_good.
- Preamble ending in 0xD4 instead of 0xD5 -> DROP with no outputs. Valid 60-byte frame with correct CRC -> 42 payload bytes, then frame_bad as undersize.
- rst asserted for 1 cycle at payload byte 20 -> all outputs 0 next cycle, no status pulse. The next valid frame -> frame_good with correct payload.
